// File: rtl/drive_pkg.sv
// Shared types and constants for the drive command path: FSM states, throttle/steer
// encodings and the decode helpers used by drive_cmd_arbiter.
package drive_pkg;

  typedef enum logic [1:0] {
    ST_FAILSAFE = 2'd0,
    ST_RUN      = 2'd1,
    ST_DEADTIME = 2'd2
  } drive_state_t;

  localparam logic [12:0] THROTTLE_CENTER = 13'd512;
  localparam logic [15:0] SERVO_CENTER    = 16'd1500;
  localparam logic [16:0] SERVO_OFFSET    = 17'd1000;
  localparam int          DUTY_SHIFT      = 3;
  localparam logic [12:0] MAG_MAX         = 13'd511;

  typedef struct packed {
    logic [15:0] duty;
    logic        fwd;
    logic        center;
  } motor_cmd_t;

  // Throttle is offset-binary around THROTTLE_CENTER; magnitude saturates so duty tops out at 4088.
  function automatic motor_cmd_t decode_throttle(input logic [12:0] t);
    motor_cmd_t  c;
    logic [12:0] mag;
    mag = (t > THROTTLE_CENTER) ? t - THROTTLE_CENTER : THROTTLE_CENTER - t;
    if (mag > MAG_MAX) mag = MAG_MAX;
    c.duty   = {3'b000, mag} << DUTY_SHIFT;
    c.fwd    = (t > THROTTLE_CENTER);
    c.center = (t == THROTTLE_CENTER);
    return c;
  endfunction

  // A carry out of the 16-bit add counts as an over-range pulse width.
  function automatic logic [15:0] clamp_servo(input logic [15:0] steer,
                                              input logic [15:0] lo,
                                              input logic [15:0] hi);
    logic [16:0] sum;
    sum = {1'b0, steer} + SERVO_OFFSET;
    if (sum[16] || (sum[15:0] > hi)) return hi;
    if (sum[15:0] < lo) return lo;
    return sum[15:0];
  endfunction

endpackage

// File: rtl/drive_cmd_arbiter_if.sv
// Command/actuator bundle between the command sources, drive_cmd_arbiter and the PWM blocks.
interface drive_cmd_arbiter_if;
  logic        tick_1k;
  logic        mode_remote;
  logic        rem_valid;
  logic [15:0] rem_steer;
  logic [15:0] rem_throttle;
  logic        auto_valid;
  logic [15:0] auto_steer;
  logic [15:0] auto_throttle;
  logic [15:0] motor_duty;
  logic        motor_a;
  logic        motor_b;
  logic [15:0] servo_duty;
  logic        failsafe;

  modport master (
    output tick_1k, mode_remote, rem_valid, rem_steer, rem_throttle,
           auto_valid, auto_steer, auto_throttle,
    input  motor_duty, motor_a, motor_b, servo_duty, failsafe
  );

  modport slave (
    input  tick_1k, mode_remote, rem_valid, rem_steer, rem_throttle,
           auto_valid, auto_steer, auto_throttle,
    output motor_duty, motor_a, motor_b, servo_duty, failsafe
  );
endinterface

// File: rtl/drive_tick_timer.sv
// Counts tick_1k strobes up to TERMINAL and holds there; clr restarts from zero.
module drive_tick_timer #(
  parameter int TERMINAL = 250,
  parameter int W        = $clog2(TERMINAL + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic done
);
  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               count_reg <= '0;
    else if (clr)             count_reg <= '0;
    else if (tick && !done)   count_reg <= count_reg + W'(1);
  end

  assign done = (count_reg == W'(TERMINAL));
endmodule

// File: rtl/drive_cmd_arbiter.sv
// Motor/servo command arbiter: source select, throttle/steer decode, link-loss failsafe and
// reversal dead-time. Define DRIVE_SLEW_LIMIT_EN to ramp motor_duty by SLEW_STEP per tick_1k.
import drive_pkg::*;

module drive_cmd_arbiter #(
  parameter int          TIMEOUT_MS  = 250,
  parameter int          DEADTIME_MS = 20,
  parameter logic [15:0] SERVO_MIN   = 16'd1000,
  parameter logic [15:0] SERVO_MAX   = 16'd2000
`ifdef DRIVE_SLEW_LIMIT_EN
  , parameter logic [15:0] SLEW_STEP = 16'd64
`endif
) (
  input logic                clk,
  input logic                rst_n,
  drive_cmd_arbiter_if.slave bus
);
  drive_state_t state_reg, state_next;
  logic         mode_prev_reg;
  logic [15:0]  motor_duty_reg, motor_duty_next;
  logic [15:0]  servo_reg, servo_next;
  logic         motor_a_reg, motor_a_next, motor_b_reg, motor_b_next;
  motor_cmd_t   pend_reg, pend_next;
`ifdef DRIVE_SLEW_LIMIT_EN
  logic [15:0]  target_reg, target_next;
  logic         rev_pend_reg, rev_pend_next;

  function automatic logic [15:0] slew_toward(input logic [15:0] cur, input logic [15:0] tgt);
    if (tgt > cur) return ((tgt - cur) > SLEW_STEP) ? cur + SLEW_STEP : tgt;
    return ((cur - tgt) > SLEW_STEP) ? cur - SLEW_STEP : tgt;
  endfunction
`endif

  logic        toggle, accept, opposite, reversal, wd_done, dt_done;
  logic [12:0] sel_thr;
  logic [15:0] sel_steer, sel_servo;
  motor_cmd_t  sel_cmd, run_cmd;

  // A valid arriving with a mode change belongs to the old source and is dropped.
  assign toggle    = (bus.mode_remote != mode_prev_reg);
  assign accept    = !toggle && (bus.mode_remote ? bus.rem_valid : bus.auto_valid);
  assign sel_thr   = bus.mode_remote ? bus.rem_throttle[12:0] : bus.auto_throttle[12:0];
  assign sel_steer = bus.mode_remote ? bus.rem_steer : bus.auto_steer;
  assign sel_cmd   = decode_throttle(sel_thr);
  assign sel_servo = clamp_servo(sel_steer, SERVO_MIN, SERVO_MAX);
  assign run_cmd   = accept ? sel_cmd : pend_reg;
  assign opposite  = !sel_cmd.center && (sel_cmd.fwd ? motor_b_reg : motor_a_reg);
`ifdef DRIVE_SLEW_LIMIT_EN
  assign reversal  = opposite && ((motor_duty_reg != 16'd0) || rev_pend_reg);
`else
  assign reversal  = opposite && (motor_duty_reg != 16'd0);
`endif

  drive_tick_timer #(.TERMINAL(TIMEOUT_MS)) u_watchdog (
    .clk(clk), .rst_n(rst_n), .clr(accept || toggle), .tick(bus.tick_1k), .done(wd_done)
  );

  drive_tick_timer #(.TERMINAL(DEADTIME_MS)) u_deadtime (
    .clk(clk), .rst_n(rst_n), .clr(state_reg != ST_DEADTIME), .tick(bus.tick_1k), .done(dt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_FAILSAFE;
      mode_prev_reg  <= 1'b0;
      motor_duty_reg <= '0;
      motor_a_reg    <= 1'b0;
      motor_b_reg    <= 1'b0;
      servo_reg      <= SERVO_CENTER;
      pend_reg       <= '0;
`ifdef DRIVE_SLEW_LIMIT_EN
      target_reg     <= '0;
      rev_pend_reg   <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      mode_prev_reg  <= bus.mode_remote;
      motor_duty_reg <= motor_duty_next;
      motor_a_reg    <= motor_a_next;
      motor_b_reg    <= motor_b_next;
      servo_reg      <= servo_next;
      pend_reg       <= pend_next;
`ifdef DRIVE_SLEW_LIMIT_EN
      target_reg     <= target_next;
      rev_pend_reg   <= rev_pend_next;
`endif
    end
  end

  // Priority: mode change, accepted command, watchdog expiry, dead-time completion.
  always_comb begin
    state_next = state_reg;
    if (toggle) begin
      state_next = ST_FAILSAFE;
    end else if (accept) begin
      unique case (state_reg)
        ST_FAILSAFE: state_next = ST_RUN;
`ifdef DRIVE_SLEW_LIMIT_EN
        ST_RUN:      if (reversal && (motor_duty_reg == 16'd0)) state_next = ST_DEADTIME;
`else
        ST_RUN:      if (reversal) state_next = ST_DEADTIME;
`endif
        ST_DEADTIME: if (dt_done) state_next = ST_RUN;
        default:     state_next = ST_FAILSAFE;
      endcase
    end else if (wd_done) begin
      state_next = ST_FAILSAFE;
    end else if ((state_reg == ST_DEADTIME) && dt_done) begin
      state_next = ST_RUN;
`ifdef DRIVE_SLEW_LIMIT_EN
    end else if ((state_reg == ST_RUN) && rev_pend_reg && (motor_duty_reg == 16'd0)) begin
      state_next = ST_DEADTIME;
`endif
    end
  end

  always_comb begin
    motor_duty_next = motor_duty_reg;
    motor_a_next    = motor_a_reg;
    motor_b_next    = motor_b_reg;
    servo_next      = servo_reg;
    pend_next       = pend_reg;
`ifdef DRIVE_SLEW_LIMIT_EN
    target_next     = target_reg;
    rev_pend_next   = rev_pend_reg;
`endif
    if (accept) begin
      servo_next = sel_servo;
      pend_next  = sel_cmd;
    end
    unique case (state_next)
      ST_FAILSAFE, ST_DEADTIME: begin
        motor_duty_next = '0;
        motor_a_next    = 1'b0;
        motor_b_next    = 1'b0;
        if (state_next == ST_FAILSAFE) servo_next = SERVO_CENTER;
`ifdef DRIVE_SLEW_LIMIT_EN
        target_next     = '0;
        rev_pend_next   = 1'b0;
`endif
      end
      ST_RUN: begin
        if ((state_reg != ST_RUN) || accept) begin
`ifdef DRIVE_SLEW_LIMIT_EN
          // Reversal while moving: ramp down on the old leg first, dead-time follows at zero.
          if ((state_reg == ST_RUN) && reversal) begin
            target_next   = '0;
            rev_pend_next = 1'b1;
          end else begin
            target_next   = run_cmd.duty;
            rev_pend_next = 1'b0;
            if (!run_cmd.center) begin
              motor_a_next = run_cmd.fwd;
              motor_b_next = !run_cmd.fwd;
            end
          end
`else
          motor_duty_next = run_cmd.duty;
          if (!run_cmd.center) begin
            motor_a_next = run_cmd.fwd;
            motor_b_next = !run_cmd.fwd;
          end
`endif
        end
      end
      default: ;
    endcase
`ifdef DRIVE_SLEW_LIMIT_EN
    if ((state_reg == ST_RUN) && (state_next == ST_RUN) && bus.tick_1k)
      motor_duty_next = slew_toward(motor_duty_reg, target_next);
`endif
  end

  assign bus.motor_duty = motor_duty_reg;
  assign bus.motor_a    = motor_a_reg;
  assign bus.motor_b    = motor_b_reg;
  assign bus.servo_duty = servo_reg;
  assign bus.failsafe   = (state_reg == ST_FAILSAFE);
endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Self-checking bench for drive_cmd_arbiter: reset/table vectors, hand-built timing sequences
// and randomized traffic checked against a cycle-level behavioural model.
module tb_drive_cmd_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  drive_cmd_arbiter_if bus();
  drive_cmd_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit rv; int rsteer; int rthr;
    bit av; int asteer; int athr;
    int duty; bit a; bit b; int servo; bit fs;
  } vec_t;
  vec_t vecs[11];

  function automatic vec_t mk(input int rv, input int rs, input int rt, input int av, input int as_,
                              input int at, input int duty, input int a, input int b,
                              input int servo, input int fs);
    vec_t v;
    v.rv = rv[0]; v.rsteer = rs; v.rthr = rt; v.av = av[0]; v.asteer = as_; v.athr = at;
    v.duty = duty; v.a = a[0]; v.b = b[0]; v.servo = servo; v.fs = fs[0];
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int duty, input int a, input int b,
                           input int servo, input int fs);
    check({name, " duty"}, int'(bus.motor_duty), duty);
    check({name, " a"}, int'(bus.motor_a), a);
    check({name, " b"}, int'(bus.motor_b), b);
    check({name, " servo"}, int'(bus.servo_duty), servo);
    check({name, " failsafe"}, int'(bus.failsafe), fs);
  endtask

  // Behavioural model: counters in plain ints, outputs recomputed from the command rules.
  int m_duty, m_servo, m_wd, m_dt, m_pthr;
  bit m_a, m_b, m_fs, m_dead, m_prev_mode;

  function automatic int duty_of(input int thr);
    int t, mag;
    t = thr % 8192;
    mag = (t > 512) ? t - 512 : 512 - t;
    if (mag > 511) mag = 511;
    return mag * 8;
  endfunction

  function automatic int servo_of(input int steer);
    int s;
    s = steer + 1000;
    if (s > 2000) s = 2000;
    if (s < 1000) s = 1000;
    return s;
  endfunction

  function automatic void m_apply(input int thr);
    int t;
    t = thr % 8192;
    m_duty = duty_of(thr);
    if (t > 512) begin m_a = 1; m_b = 0; end
    else if (t < 512) begin m_a = 0; m_b = 1; end
  endfunction

  function automatic void m_fail();
    m_fs = 1; m_dead = 0; m_duty = 0; m_a = 0; m_b = 0; m_servo = 1500;
  endfunction

  function automatic void model_reset();
    m_fail();
    m_wd = 0; m_dt = 0; m_pthr = 512; m_prev_mode = 0;
  endfunction

  function automatic void model_step();
    bit tog, acc, was_dead, wd_exp, dt_done, opp;
    int thr, steer, t;
    tog = (bus.mode_remote != m_prev_mode);
    m_prev_mode = bus.mode_remote;
    acc = !tog && (bus.mode_remote ? bus.rem_valid : bus.auto_valid);
    thr = bus.mode_remote ? int'(bus.rem_throttle) : int'(bus.auto_throttle);
    steer = bus.mode_remote ? int'(bus.rem_steer) : int'(bus.auto_steer);
    t = thr % 8192;
    opp = (t > 512 && m_b) || (t < 512 && m_a);
    was_dead = m_dead;
    wd_exp = (m_wd >= 250);
    dt_done = (m_dt >= 20);
    if (acc || tog) m_wd = 0;
    else if (bus.tick_1k && m_wd < 250) m_wd++;
    if (!was_dead) m_dt = 0;
    else if (bus.tick_1k && m_dt < 20) m_dt++;
    if (tog) m_fail();
    else if (acc) begin
      m_servo = servo_of(steer);
      if (m_fs) begin m_fs = 0; m_apply(thr); end
      else if (was_dead) begin
        m_pthr = thr;
        if (dt_done) begin m_dead = 0; m_apply(thr); end
      end else if (opp && m_duty != 0) begin
        m_dead = 1; m_duty = 0; m_a = 0; m_b = 0; m_pthr = thr;
      end else m_apply(thr);
    end else if (wd_exp) m_fail();
    else if (was_dead && dt_done) begin m_dead = 0; m_apply(m_pthr); end
  endfunction

  task automatic cycle(input bit cmp, input int idx);
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
    if (cmp) check_out($sformatf("rand%0d", idx), m_duty, m_a, m_b, m_servo, m_fs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_1k = 1; cycle(0, 0);
      bus.tick_1k = 0; idle(3);
    end
  endtask

  task automatic send(input bit rv, input int rs, input int rt, input bit av, input int as_, input int at);
    bus.rem_valid = rv; bus.rem_steer = 16'(rs); bus.rem_throttle = 16'(rt);
    bus.auto_valid = av; bus.auto_steer = 16'(as_); bus.auto_throttle = 16'(at);
    cycle(0, 0);
    bus.rem_valid = 0; bus.auto_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle(3);
    rst_n = 1;
    idle(2);
  endtask

  initial begin
    #3ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rate;
    vecs[0]  = mk(1, 500,   812,   0, 0, 0,   2400, 1, 0, 1500, 0);
    vecs[1]  = mk(1, 0,     513,   0, 0, 0,   8,    1, 0, 1000, 0);
    vecs[2]  = mk(1, 2000,  512,   0, 0, 0,   0,    1, 0, 2000, 0);
    vecs[3]  = mk(1, 65535, 0,     0, 0, 0,   4088, 0, 1, 2000, 0);
    vecs[4]  = mk(1, 700,   57728, 0, 0, 0,   1024, 0, 1, 1700, 0);
    vecs[5]  = mk(1, 200,   512,   0, 0, 0,   0,    0, 1, 1200, 0);
    vecs[6]  = mk(1, 1000,  600,   0, 0, 0,   704,  1, 0, 2000, 0);
    vecs[7]  = mk(1, 999,   1023,  0, 0, 0,   4088, 1, 0, 1999, 0);
    vecs[8]  = mk(1, 100,   1024,  0, 0, 0,   4088, 1, 0, 1100, 0);
    vecs[9]  = mk(0, 0,     0,     1, 0, 100, 4088, 1, 0, 1100, 0);
    vecs[10] = mk(1, 500,   200,   0, 0, 0,   0,    0, 0, 1500, 0);

    bus.tick_1k = 0; bus.mode_remote = 0;
    bus.rem_valid = 0; bus.rem_steer = 0; bus.rem_throttle = 16'd512;
    bus.auto_valid = 0; bus.auto_steer = 0; bus.auto_throttle = 16'd512;
    do_reset();
    check_out("reset", 0, 0, 0, 1500, 1);
    $display("txn reset: duty=%0d fs=%0d", bus.motor_duty, bus.failsafe);

`ifndef DRIVE_SLEW_LIMIT_EN
    bus.mode_remote = 1;
    tick_n(1000);
    check_out("idle_1000_ticks", 0, 0, 0, 1500, 1);
    $display("txn idle 1000 ticks: duty=%0d fs=%0d", bus.motor_duty, bus.failsafe);

    for (int i = 0; i < 11; i++) begin
      send(vecs[i].rv, vecs[i].rsteer, vecs[i].rthr, vecs[i].av, vecs[i].asteer, vecs[i].athr);
      check_out($sformatf("vec%0d", i), vecs[i].duty, vecs[i].a, vecs[i].b, vecs[i].servo, vecs[i].fs);
      $display("txn vec%0d: thr=%0d steer=%0d -> duty=%0d a=%0d b=%0d servo=%0d fs=%0d", i,
               vecs[i].rv ? vecs[i].rthr : vecs[i].athr, vecs[i].rv ? vecs[i].rsteer : vecs[i].asteer,
               bus.motor_duty, bus.motor_a, bus.motor_b, bus.servo_duty, bus.failsafe);
    end

    // Reversal dead-time: exactly 20 ticks with the bridge off
    do_reset();
    send(1, 500, 812, 0, 0, 0);
    check_out("rev_start", 2400, 1, 0, 1500, 0);
    send(1, 500, 312, 0, 0, 0);
    check_out("rev_dead_entry", 0, 0, 0, 1500, 0);
    tick_n(19);
    check_out("rev_dead_19", 0, 0, 0, 1500, 0);
    tick_n(1);
    check_out("rev_dead_20", 1600, 0, 1, 1500, 0);
    $display("txn reversal: duty=%0d a=%0d b=%0d", bus.motor_duty, bus.motor_a, bus.motor_b);

    // Watchdog: 20 ticks already elapsed since the last accepted command
    tick_n(229);
    check("wd_249 failsafe", int'(bus.failsafe), 0);
    tick_n(1);
    check_out("wd_250", 0, 0, 0, 1500, 1);
    send(1, 800, 312, 0, 0, 0);
    check_out("wd_recover", 1600, 0, 1, 1800, 0);
    $display("txn watchdog recover: duty=%0d b=%0d fs=%0d", bus.motor_duty, bus.motor_b, bus.failsafe);

    // Mode change forces failsafe; only the selected source is honoured
    bus.mode_remote = 0;
    cycle(0, 0);
    check_out("mode_toggle", 0, 0, 0, 1500, 1);
    idle(1);
    send(1, 100, 900, 1, 300, 600);
    check_out("auto_select", 704, 1, 0, 1300, 0);
    $display("txn auto select: duty=%0d a=%0d servo=%0d", bus.motor_duty, bus.motor_a, bus.servo_duty);

    bus.mode_remote = 1;
    send(1, 500, 812, 0, 0, 0);
    check_out("toggle_valid_ignored", 0, 0, 0, 1500, 1);
    idle(1);

    // Timeout and accepted command on the same cycle: command wins
    send(1, 500, 812, 0, 0, 0);
    check_out("pre_race", 2400, 1, 0, 1500, 0);
    tick_n(249);
    bus.tick_1k = 1;
    send(1, 0, 612, 0, 0, 0);
    bus.tick_1k = 0;
    idle(3);
    check_out("race_cmd_wins", 800, 1, 0, 1000, 0);
    tick_n(249);
    check("race_wd_cleared failsafe", int'(bus.failsafe), 0);
    $display("txn timeout race: duty=%0d fs=%0d", bus.motor_duty, bus.failsafe);

    // Asynchronous reset takes effect without a clock edge
    rst_n = 0;
    #1;
    check_out("async_reset", 0, 0, 0, 1500, 1);
    idle(2);
    rst_n = 1;
    idle(2);

    // Randomized traffic against the model, alternating busy and quiet phases
    for (int i = 0; i < 6000; i++) begin
      int r;
      rate = ((i / 1500) % 2 == 1) ? 1200 : 30;
      bus.tick_1k = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 599) == 0) bus.mode_remote = ~bus.mode_remote;
      bus.rem_valid = ($urandom_range(0, rate) == 0);
      bus.auto_valid = ($urandom_range(0, rate) == 0);
      r = $urandom_range(0, 3);
      bus.rem_throttle = (r == 0) ? 16'd512 : (r == 1) ? 16'($urandom_range(0, 1023)) :
                         (r == 2) ? 16'($urandom) : 16'($urandom_range(400, 624));
      bus.auto_throttle = 16'($urandom_range(0, 1023));
      bus.rem_steer = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1100));
      bus.auto_steer = 16'($urandom_range(0, 1100));
      if (bus.rem_valid || bus.auto_valid)
        $display("txn rand%0d: mode=%0d rv=%0d rthr=%0d av=%0d athr=%0d", i, bus.mode_remote,
                 bus.rem_valid, bus.rem_throttle, bus.auto_valid, bus.auto_throttle);
      cycle(1, i);
    end
`else
    bus.mode_remote = 1;
    idle(2);
    send(1, 500, 1023, 0, 0, 0);
    tick_n(63);
    check("slew_63 duty", int'(bus.motor_duty), 4032);
    tick_n(1);
    check("slew_64 duty", int'(bus.motor_duty), 4088);
    $display("txn slew ramp: duty=%0d", bus.motor_duty);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
